// File: rtl/approx_mult_pkg.sv
// Shared types and defaults for the approximate-multiplier error-metric stage.
package approx_mult_pkg;
    localparam int P_W_DEF   = 32;
    localparam int ACC_W_DEF = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/err_dist_abs.sv
// Combinational error distance between an approximate and an exact product.
module err_dist_abs
    import approx_mult_pkg::*;
#(
    parameter int P_W = P_W_DEF
) (
    input  logic [P_W-1:0] approx_p,
    input  logic [P_W-1:0] exact_p,
    output logic [P_W-1:0] ed,
    output logic           ne,
    output logic           ov
);
    logic [P_W:0] diff;

    // Extra bit makes the borrow the over-estimate flag.
    assign diff = {1'b0, exact_p} - {1'b0, approx_p};
    assign ov   = diff[P_W];
    assign ne   = |diff;
    assign ed   = ov ? (approx_p - exact_p) : (exact_p - approx_p);
endmodule

// File: rtl/approx_mult_err_accum.sv
// Accumulates error statistics (count, over-count, ED sum, ED max) over a run of product pairs.
module approx_mult_err_accum
    import approx_mult_pkg::*;
#(
    parameter int P_W       = P_W_DEF,
    parameter int N_SAMPLES = 1024,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1),
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   approx_p,
    input  logic [P_W-1:0]   exact_p,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] over_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [P_W-1:0]   ed_max
);
    localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] sampleCnt;
    logic             accept, lastAccept, clearStats;
    logic [P_W-1:0]   ed;
    logic             ne, ov;
    logic             s1Vld, s1Ne, s1Ov;
    logic [P_W-1:0]   s1Ed;
    logic [ACC_W:0]   sumExt;

    err_dist_abs #(.P_W(P_W)) uDist (
        .approx_p(approx_p),
        .exact_p (exact_p),
        .ed      (ed),
        .ne      (ne),
        .ov      (ov)
    );

    assign in_ready   = (state == RUN) && (sampleCnt < N_CNT);
    assign accept     = in_valid && in_ready;
    assign lastAccept = accept && (sampleCnt == N_LAST);
    assign clearStats = start && ((state == IDLE) || (state == DONE));
    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (start)      stateNext = RUN;
            RUN:        if (lastAccept) stateNext = DRAIN;
            // Last pair sits in stage 1 on the first DRAIN cycle; leave once it has drained.
            DRAIN:      if (!s1Vld)     stateNext = DONE;
            default:                    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sampleCnt <= '0;
        end else begin
            state <= stateNext;
            if (clearStats)  sampleCnt <= '0;
            else if (accept) sampleCnt <= sampleCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Vld <= 1'b0;
            s1Ed  <= '0;
            s1Ne  <= 1'b0;
            s1Ov  <= 1'b0;
        end else begin
            s1Vld <= accept;
            if (accept) begin
                s1Ed <= ed;
                s1Ne <= ne;
                s1Ov <= ov;
            end
        end
    end

    assign sumExt = {1'b0, ed_sum} + (ACC_W + 1)'(s1Ed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            over_cnt <= '0;
            ed_sum   <= '0;
            ed_max   <= '0;
        end else if (clearStats) begin
            err_cnt  <= '0;
            over_cnt <= '0;
            ed_sum   <= '0;
            ed_max   <= '0;
        end else if (s1Vld) begin
            err_cnt  <= err_cnt + CNT_W'(s1Ne);
            over_cnt <= over_cnt + CNT_W'(s1Ov);
            ed_sum   <= sumExt[ACC_W] ? '1 : sumExt[ACC_W-1:0];
            if (s1Ed > ed_max) ed_max <= s1Ed;
        end
    end
endmodule
